// File: rtl/pong_pkg.sv
// Shared definitions for the pong game logic and renderer: screen and
// sprite geometry, centre position, FSM state and direction encodings.
package pong_pkg;

    localparam int H_VIDEO       = 640;
    localparam int V_VIDEO       = 480;
    localparam int SQUARE_WIDTH  = 16;
    localparam int PADDLE_WIDTH  = 12;
    localparam int PADDLE_HEIGHT = 96;

    // Largest top-left coordinate that keeps the whole ball on screen.
    localparam int X_MAX = H_VIDEO - 1 - SQUARE_WIDTH;
    localparam int Y_MAX = V_VIDEO - 1 - SQUARE_WIDTH;

    // Ball rest position between points.
    localparam int CENTRE_X = (H_VIDEO - SQUARE_WIDTH) / 2;
    localparam int CENTRE_Y = (V_VIDEO - SQUARE_WIDTH) / 2;

    // Width of the per-frame step; holds any legal speed up to 15.
    localparam int SPEED_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        PLAY,
        GAME_OVER
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_x_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_y_t;

    // Screen coordinates are 10 bits; motion maths runs in 11 bits so that
    // sums never wrap.
    function automatic logic [10:0] widen(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/paddle_hit_detect.sv
// Combinational overlap test between the ball (at a candidate x and the
// current y) and one paddle rectangle. Both spans are inclusive at each end.
module paddle_hit_detect
    import pong_pkg::*;
(
    input  logic [10:0] ball_x,
    input  logic [9:0]  ball_y,
    input  logic [9:0]  paddle_x,
    input  logic [9:0]  paddle_y,
    output logic        hit
);

    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] by;
    logic        overlap_x;
    logic        overlap_y;

    assign px = widen(paddle_x);
    assign py = widen(paddle_y);
    assign by = widen(ball_y);

    // Two closed intervals overlap when each one starts before the other ends.
    always_comb begin
        overlap_x = (ball_x <= px + 11'(PADDLE_WIDTH)) && (ball_x + 11'(SQUARE_WIDTH) >= px);
        overlap_y = (by <= py + 11'(PADDLE_HEIGHT)) && (by + 11'(SQUARE_WIDTH) >= py);
        hit       = overlap_x && overlap_y;
    end

endmodule

// File: rtl/ball_controller.sv
// Pong game logic: ball motion, wall and paddle bounces, scoring, serve
// delay and end-of-game detection. Motion advances once per frame_tick.
// Optional build macro SPEEDUP_EN: each paddle hit raises the ball speed by
// one, saturating at MAX_SPEED, and every serve restores BALL_SPEED.
module ball_controller
    import pong_pkg::*;
#(
    parameter int BALL_SPEED   = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 11
`ifdef SPEEDUP_EN
    ,
    parameter int MAX_SPEED    = 8
`endif
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] paddle1_xpos,
    input  logic [9:0] paddle1_ypos,
    input  logic [9:0] paddle2_xpos,
    input  logic [9:0] paddle2_ypos,
    output logic [9:0] square_xpos,
    output logic [9:0] square_ypos,
    output logic       sq_shown,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       game_over
);

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    state_t             state, state_next;
    logic               start_q;
    logic               start_rise;

    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    dir_x_t             dir_x, dir_x_d;
    dir_y_t             dir_y, dir_y_d;
    logic [3:0]         score_p1_q, score_p1_d;
    logic [3:0]         score_p2_q, score_p2_d;
    logic               shown_q, shown_d;
    logic               over_q, over_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               serve_load;

    logic [SPEED_W-1:0] speed;
    logic [10:0]        x_w;
    logic [10:0]        y_w;
    logic [10:0]        spd_w;
    logic [10:0]        cand_x;
    logic               hit_p1;
    logic               hit_p2;

    logic [9:0]         step_x;
    logic [9:0]         step_y;
    dir_x_t             step_dir_x;
    dir_y_t             step_dir_y;
    logic               paddle_hit;
    logic               point_p1;
    logic               point_p2;
    logic [3:0]         score_p1_inc;
    logic [3:0]         score_p2_inc;
    logic               win;

`ifdef SPEEDUP_EN
    logic [SPEED_W-1:0] speed_q, speed_d;
    assign speed = speed_q;
`else
    assign speed = SPEED_W'(BALL_SPEED);
`endif

    assign start_rise = start & ~start_q;
    assign x_w        = widen(x_q);
    assign y_w        = widen(y_q);
    assign spd_w      = 11'(speed);

    // Candidate x used by the paddle test; a leftward step clamps at 0.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        cand_x = x_w + spd_w;
        if (dir_x == DIR_LEFT) begin
            cand_x = (x_w < spd_w) ? 11'd0 : x_w - spd_w;
        end
    end

    paddle_hit_detect u_hit_p1 (
        .ball_x   (cand_x),
        .ball_y   (y_q),
        .paddle_x (paddle1_xpos),
        .paddle_y (paddle1_ypos),
        .hit      (hit_p1)
    );

    paddle_hit_detect u_hit_p2 (
        .ball_x   (cand_x),
        .ball_y   (y_q),
        .paddle_x (paddle2_xpos),
        .paddle_y (paddle2_ypos),
        .hit      (hit_p2)
    );

    // Vertical step with bounces off the top and bottom walls.
    always_comb begin
        step_y     = y_q;
        step_dir_y = dir_y;
        if (dir_y == DIR_UP) begin
            if (y_w < spd_w) begin
                step_y     = '0;
                step_dir_y = DIR_DOWN;
            end else begin
                step_y = 10'(y_w - spd_w);
            end
        end else begin
            if (y_w + spd_w > 11'(Y_MAX)) begin
                step_y     = 10'(Y_MAX);
                step_dir_y = DIR_UP;
            end else begin
                step_y = 10'(y_w + spd_w);
            end
        end
    end

    // Horizontal step: a paddle on the approaching side wins over a miss,
    // which wins over plain motion.
    always_comb begin
        step_x     = 10'(cand_x);
        step_dir_x = dir_x;
        paddle_hit = 1'b0;
        point_p1   = 1'b0;
        point_p2   = 1'b0;
        if (dir_x == DIR_LEFT && hit_p1) begin
            step_x     = 10'(widen(paddle1_xpos) + 11'(PADDLE_WIDTH + 1));
            step_dir_x = DIR_RIGHT;
            paddle_hit = 1'b1;
        end else if (dir_x == DIR_RIGHT && hit_p2) begin
            step_x     = 10'(widen(paddle2_xpos) - 11'(SQUARE_WIDTH + 1));
            step_dir_x = DIR_LEFT;
            paddle_hit = 1'b1;
        end else if (dir_x == DIR_LEFT && x_w < spd_w) begin
            point_p2 = 1'b1;
        end else if (dir_x == DIR_RIGHT && x_w + spd_w > 11'(X_MAX)) begin
            point_p1 = 1'b1;
        end
    end

    assign score_p1_inc = score_p1_q + 4'd1;
    assign score_p2_inc = score_p2_q + 4'd1;
    assign win = (point_p1 && score_p1_inc == 4'(WIN_SCORE)) ||
                 (point_p2 && score_p2_inc == 4'(WIN_SCORE));

    // State register and start-key history.
    always_ff @(posedge clk_0) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_next;
            start_q <= start;
        end
    end

    // Next-state decision.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (start_rise) state_next = SERVE;
            SERVE:     if (frame_tick && cnt_q == '0) state_next = PLAY;
            PLAY:      if (frame_tick && (point_p1 || point_p2)) state_next = win ? GAME_OVER : SERVE;
            GAME_OVER: if (start_rise) state_next = SERVE;
        endcase
    end

    // Next values of the ball, scores, counter and visibility for each state.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        dir_x_d    = dir_x;
        dir_y_d    = dir_y;
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
        shown_d    = shown_q;
        over_d     = over_q;
        cnt_d      = cnt_q;
        serve_load = 1'b0;
`ifdef SPEEDUP_EN
        speed_d    = speed_q;
`endif
        unique case (state)
            IDLE: begin
                if (start_rise) begin
                    score_p1_d = '0;
                    score_p2_d = '0;
                    serve_load = 1'b1;
                end
            end
            SERVE: begin
                if (frame_tick && cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            PLAY: begin
                if (frame_tick) begin
                    if (point_p1 || point_p2) begin
                        if (point_p1) score_p1_d = score_p1_inc;
                        if (point_p2) score_p2_d = score_p2_inc;
                        if (win) begin
                            over_d  = 1'b1;
                            shown_d = 1'b0;
                            x_d     = 10'(CENTRE_X);
                            y_d     = 10'(CENTRE_Y);
                        end else begin
                            serve_load = 1'b1;
                            // Next serve travels toward the player who conceded.
                            dir_x_d    = point_p1 ? DIR_RIGHT : DIR_LEFT;
                        end
                    end else begin
                        x_d     = step_x;
                        y_d     = step_y;
                        dir_x_d = step_dir_x;
                        dir_y_d = step_dir_y;
`ifdef SPEEDUP_EN
                        if (paddle_hit && speed_q < SPEED_W'(MAX_SPEED)) speed_d = speed_q + 1'b1;
`endif
                    end
                end
            end
            GAME_OVER: begin
                if (start_rise) begin
                    score_p1_d = '0;
                    score_p2_d = '0;
                    over_d     = 1'b0;
                    serve_load = 1'b1;
                end
            end
        endcase
        if (serve_load) begin
            x_d     = 10'(CENTRE_X);
            y_d     = 10'(CENTRE_Y);
            cnt_d   = CNT_W'(SERVE_FRAMES);
            shown_d = 1'b1;
`ifdef SPEEDUP_EN
            speed_d = SPEED_W'(BALL_SPEED);
`endif
        end
    end

    // Game registers; every output is taken straight from here.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            x_q        <= 10'(CENTRE_X);
            y_q        <= 10'(CENTRE_Y);
            dir_x      <= DIR_RIGHT;
            dir_y      <= DIR_DOWN;
            score_p1_q <= '0;
            score_p2_q <= '0;
            shown_q    <= 1'b0;
            over_q     <= 1'b0;
            cnt_q      <= '0;
`ifdef SPEEDUP_EN
            speed_q    <= SPEED_W'(BALL_SPEED);
`endif
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            dir_x      <= dir_x_d;
            dir_y      <= dir_y_d;
            score_p1_q <= score_p1_d;
            score_p2_q <= score_p2_d;
            shown_q    <= shown_d;
            over_q     <= over_d;
            cnt_q      <= cnt_d;
`ifdef SPEEDUP_EN
            speed_q    <= speed_d;
`endif
        end
    end

    assign square_xpos = x_q;
    assign square_ypos = y_q;
    assign sq_shown    = shown_q;
    assign score_p1    = score_p1_q;
    assign score_p2    = score_p2_q;
    assign game_over   = over_q;

endmodule
